// File: rtl/layer56_argmax_target_pkg.sv
// Shared definitions for the layer-56 argmax / target generator.
// zero2one_t is an unsigned 8-bit fraction where 8'h00 is 0.0 and 8'hFF is 1.0.
// Defines the output count of layer 56 and the controller state encoding.
package layer56_argmax_target_pkg;

    localparam int N_LAYER56_OUT = 56;

    typedef logic [7:0] zero2one_t;

    localparam zero2one_t ZERO2ONE_MIN = 8'h00;
    localparam zero2one_t ZERO2ONE_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } argmax_state_t;

endpackage

// File: rtl/layer56_argmax_target_argmax_step.sv
// argmax_step: one combinational compare/update step of a running argmax.
// This step takes one element and its index, along with the current best value and its index.
// With ARGMAX_MARGIN_EN it also takes the current second-best value.
// It returns the updated best, best index and, with the macro, the updated second-best.
// Ports:
//   elem, idx          element under test and its index
//   best, best_idx     running maximum and its index
//   second             running second-best value (ARGMAX_MARGIN_EN only)
//   best_nx, best_idx_nx, second_nx  updated values
module argmax_step
    import layer56_argmax_target_pkg::*;
#(
    parameter int IW = 6
) (
    input  zero2one_t       elem,
    input  logic [IW-1:0]   idx,
    input  zero2one_t       best,
    input  logic [IW-1:0]   best_idx,
`ifdef ARGMAX_MARGIN_EN
    input  zero2one_t       second,
    output zero2one_t       second_nx,
`endif
    output zero2one_t       best_nx,
    output logic [IW-1:0]   best_idx_nx
);

    // A strictly greater element is required to take over, so an equal value
    // arriving later never displaces an earlier index.
    // The displaced best becomes the second-best. An element that ties the best
    // is no greater than the best but is at least the second. The plain
    // "greater than second" test therefore also records ties with best.
    always_comb begin
        best_nx     = best;
        best_idx_nx = best_idx;
`ifdef ARGMAX_MARGIN_EN
        second_nx   = second;
`endif
        if (elem > best) begin
            best_nx     = elem;
            best_idx_nx = idx;
`ifdef ARGMAX_MARGIN_EN
            second_nx   = best;
`endif
        end
`ifdef ARGMAX_MARGIN_EN
        else if (elem > second) begin
            second_nx = elem;
        end
`endif
    end

endmodule

// File: rtl/layer56_argmax_target.sv
// layer56_argmax_target: snapshots the layer outputs and a label, then scans
// the outputs one per cycle to find the argmax (ties go to the lowest index).
// It reports pred/correct/label_err, produces a one-hot expected_out target
// and pulses learn when the layer should be trained on this sample.
// Optional macro ARGMAX_MARGIN_EN adds the following:
//   - second-best tracking
//   - the margin and confident outputs
//   - the MARGIN_THRESH parameter
//   - learning on correct but unconfident samples
// Ports:
//   clock, rst_n        clock, asynchronous active-low reset
//   start               begin a sample (accepted only when idle)
//   learn_req           allow a learn pulse for this sample
//   label               target class index
//   neuron_out          layer outputs to scan
//   busy                scanning or presenting a result
//   done                one-cycle result-valid pulse
//   pred, correct, label_err, expected_out  held results
//   learn               one-cycle training pulse
//   margin, confident   best minus second-best and its threshold test (macro only)
module layer56_argmax_target
    import layer56_argmax_target_pkg::*;
#(
    parameter int N_OUT = N_LAYER56_OUT,
`ifdef ARGMAX_MARGIN_EN
    parameter zero2one_t MARGIN_THRESH = zero2one_t'(ZERO2ONE_MIN + 1),
`endif
    localparam int IW = $clog2(N_OUT)
) (
    input  logic                    clock,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    learn_req,
    input  logic [IW-1:0]           label,
    input  zero2one_t [N_OUT-1:0]   neuron_out,
    output logic                    busy,
    output logic                    done,
    output logic [IW-1:0]           pred,
    output logic                    correct,
    output logic                    label_err,
    output zero2one_t [N_OUT-1:0]   expected_out,
    output logic                    learn
`ifdef ARGMAX_MARGIN_EN
    ,
    output zero2one_t               margin,
    output logic                    confident
`endif
);

    argmax_state_t state, state_nx;

    zero2one_t [N_OUT-1:0] snap;
    logic [IW-1:0]         snap_label;
    logic                  snap_learn;
    logic [IW-1:0]         cnt;
    zero2one_t             best, best_nx;
    logic [IW-1:0]         best_idx, best_idx_nx;
`ifdef ARGMAX_MARGIN_EN
    zero2one_t             second, second_nx;
    zero2one_t             margin_nx;
    logic                  confident_nx;
`endif

    logic                  last_elem;
    logic                  err_nx;
    logic                  correct_nx;
    logic                  learn_nx;
    zero2one_t [N_OUT-1:0] expected_nx;

    argmax_step #(.IW(IW)) u_step (
        .elem        (snap[cnt]),
        .idx         (cnt),
        .best        (best),
        .best_idx    (best_idx),
`ifdef ARGMAX_MARGIN_EN
        .second      (second),
        .second_nx   (second_nx),
`endif
        .best_nx     (best_nx),
        .best_idx_nx (best_idx_nx)
    );

    // State register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // The controller spends one cycle per element in SCAN, then one cycle in DONE.
    // DONE always returns to IDLE, so a start arriving in DONE is dropped.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_SCAN;
            ST_SCAN: if (last_elem) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    // Result values, computed from the final scan step, are ready to register
    // on the last SCAN cycle. The label check is widened by a bit so that an
    // N_OUT that is a power of two still compares correctly.
    always_comb begin
        last_elem  = (cnt == IW'(N_OUT - 1));
        err_nx     = ({1'b0, snap_label} >= (IW + 1)'(N_OUT));
        correct_nx = !err_nx && (best_idx_nx == snap_label);
`ifdef ARGMAX_MARGIN_EN
        margin_nx    = best_nx - second_nx;
        confident_nx = (margin_nx >= MARGIN_THRESH);
        learn_nx     = snap_learn && !err_nx && (!correct_nx || !confident_nx);
`else
        learn_nx     = snap_learn && !err_nx && !correct_nx;
`endif
        for (int i = 0; i < N_OUT; i++) begin
            expected_nx[i] = (!err_nx && snap_label == IW'(i)) ? ZERO2ONE_MAX : ZERO2ONE_MIN;
        end
    end

    // Snapshot on an accepted start, advance the argmax each SCAN cycle and
    // register the held results as the controller enters DONE.
    // The best value starts at the minimum with index 0. The scan includes element 0,
    // so the outcome is the same as seeding with element 0.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            snap         <= '0;
            snap_label   <= '0;
            snap_learn   <= 1'b0;
            cnt          <= '0;
            best         <= ZERO2ONE_MIN;
            best_idx     <= '0;
            done         <= 1'b0;
            learn        <= 1'b0;
            pred         <= '0;
            correct      <= 1'b0;
            label_err    <= 1'b0;
            expected_out <= {N_OUT{ZERO2ONE_MIN}};
`ifdef ARGMAX_MARGIN_EN
            second       <= ZERO2ONE_MIN;
            margin       <= ZERO2ONE_MIN;
            confident    <= 1'b0;
`endif
        end else begin
            done  <= 1'b0;
            learn <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        snap       <= neuron_out;
                        snap_label <= label;
                        snap_learn <= learn_req;
                        cnt        <= '0;
                        best       <= ZERO2ONE_MIN;
                        best_idx   <= '0;
`ifdef ARGMAX_MARGIN_EN
                        second     <= ZERO2ONE_MIN;
`endif
                    end
                end
                ST_SCAN: begin
                    best     <= best_nx;
                    best_idx <= best_idx_nx;
`ifdef ARGMAX_MARGIN_EN
                    second   <= second_nx;
`endif
                    if (last_elem) begin
                        cnt          <= '0;
                        done         <= 1'b1;
                        learn        <= learn_nx;
                        pred         <= best_idx_nx;
                        correct      <= correct_nx;
                        label_err    <= err_nx;
                        expected_out <= expected_nx;
`ifdef ARGMAX_MARGIN_EN
                        margin       <= margin_nx;
                        confident    <= confident_nx;
`endif
                    end else begin
                        cnt <= cnt + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/layer56_argmax_target.md
LAYER56_ARGMAX_TARGET -- requirements
Module: layer56_argmax_target

Interface
REQ-001 Parameter N_OUT, default 56, number of neuron outputs scanned (index width IW = $clog2(N_OUT)).
REQ-002 Parameter MARGIN_THRESH, default ZERO2ONE_MIN+1 (zero2one_t), minimum top1-top2 margin for confident.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  request to snapshot outputs and label; accepted only in IDLE.
REQ-006 learn_req  in  1  sampled with start; enables the learn pulse for this sample.
REQ-007 label  in  IW  target class, sampled with start.
REQ-008 neuron_out  in  zero2one_t[N_OUT]  layer outputs, sampled with start.
REQ-009 busy  out  1  high in SCAN and DONE.
REQ-010 done  out  1  one-cycle pulse when the result is valid.
REQ-011 pred  out  IW  index of the maximum output, held until the next done.
REQ-012 correct  out  1  pred == label, held with pred.
REQ-013 label_err  out  1  captured label >= N_OUT, held with pred.
REQ-014 expected_out  out  zero2one_t[N_OUT]  one-hot target vector for the layer's expected_out input.
REQ-015 learn  out  1  one-cycle pulse to the layer's learn input.

Function
REQ-016 FSM states: IDLE, SCAN, DONE; IDLE->SCAN on start, SCAN->DONE after index N_OUT-1 is compared, DONE->IDLE unconditionally after one cycle.
REQ-017 Start accepted in IDLE on cycle T: neuron_out, label, learn_req registered into snapshot registers at the end of T; later input changes have no effect.
REQ-018 SCAN compares one snapshot element per cycle, index counter 0..N_OUT-1; best starts as element 0 at index 0.
REQ-019 Replace best only when element > best (unsigned, strict), so ties resolve to the lowest index.
REQ-020 done, pred, correct, label_err, expected_out update in cycle T+N_OUT+1 (57 for default); busy is high from T+1 through T+N_OUT+1.
REQ-021 expected_out[label] = ZERO2ONE_MAX, all other elements = ZERO2ONE_MIN; label_err gives all ZERO2ONE_MIN.
REQ-022 learn pulses in the done cycle iff learn_req_captured && !label_err && !correct.
REQ-023 start while busy is ignored, not queued; start and the DONE->IDLE transition in the same cycle: start is ignored.
REQ-024 expected_out, pred, correct, label_err hold their values between done pulses.

Reset
REQ-025 rst_n low asynchronously forces IDLE, busy=0, done=0, learn=0, pred=0, correct=0, label_err=0, all expected_out=ZERO2ONE_MIN, counter=0.
REQ-026 Reset mid-SCAN aborts the sample: no done and no learn pulse follow it.

Configuration
REQ-027 Macro ARGMAX_MARGIN_EN defined: second-best is tracked (ties with best count as second); outputs margin (zero2one_t, best-second) and confident (margin >= MARGIN_THRESH) update with done; learn additionally fires when correct && !confident.
REQ-028 ARGMAX_MARGIN_EN undefined: no margin/confident ports, no second-best logic; learn rule is REQ-022 only.

Structure
REQ-029 zero2one_t, ZERO2ONE_MAX, ZERO2ONE_MIN and N_LAYER56_OUT=56 live in the shared defs package; no new typedefs local to this module.
REQ-030 One sub-module: argmax_step, a combinational compare/update of (best, best_idx[, second]) with one element, instanced once and reused each SCAN cycle.

Verification
REQ-031 All outputs ZERO2ONE_MIN except neuron_out[17]=ZERO2ONE_MAX, label=17, learn_req=1 -> done at T+57, pred=17, correct=1, learn=0, expected_out[17]=MAX.
REQ-032 Equal maxima at indices 5 and 40, label=40, learn_req=1 -> pred=5, correct=0, learn pulse 1 cycle, expected_out[40]=MAX, others MIN.
REQ-033 label=60 -> label_err=1, expected_out all MIN, learn=0 regardless of learn_req.
REQ-034 Second start at T+10 and neuron_out changed after T -> ignored, result equals snapshot at T, single done pulse.
REQ-035 rst_n low at T+30 -> outputs at reset values immediately, no done/learn; new start after release gives a correct result.
REQ-036 ARGMAX_MARGIN_EN: best=0.50, second=0.49, MARGIN_THRESH above 0.01, correct label -> confident=0, learn pulses.
